pixel_frame_ctrl: RTL and testbench

Frame sequencer for the pixel array. On a start request it runs one global-shutter frame: erase all pixels, expose them, then run the ramp conversion. It then scans every pixel in raster order, asserting the pixel read and address lines, and captures each 8-bit sample into a registered output port with a valid/ready handshake. It sits between the top-level camera control and the pixel array, and owns all pixel-array control inputs.

---
 rtl/pixel_frame_ctrl.sv | 156 +++++++++++++++
 tb/tb_pixel_frame_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_frame_ctrl.sv
// Global-shutter frame sequencer: erase/expose/convert phases, then a raster
// readout of the pixel array with a registered valid/ready sample port.
package pixel_frame_ctrl_pkg;
  function automatic int unsigned isqrt(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 1; i * i <= n; i++) r = i;
    return r;
  endfunction
endpackage

module pixel_frame_ctrl
  import pixel_frame_ctrl_pkg::*;
#(
  parameter int unsigned num_pixels     = 4,
  parameter int unsigned ERASE_CYCLES   = 4,
  parameter int unsigned EXPOSE_CYCLES  = 10,
  parameter int unsigned CONVERT_CYCLES = 16,
  localparam int unsigned SIDE = isqrt(num_pixels),
  localparam int unsigned AW   = (SIDE > 1) ? $clog2(SIDE) : 1,
  localparam int unsigned IW   = (num_pixels > 1) ? $clog2(num_pixels) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  output logic          busy,
  output logic          frame_done,
  output logic          arr_reset_n,
  output logic          arr_erase,
  output logic          arr_expose,
  output logic          arr_bias,
  output logic          arr_ramp,
  output logic          arr_read,
  output logic [AW-1:0] arr_row_addr,
  output logic [AW-1:0] arr_col_addr,
  input  logic [7:0]    arr_data,
  output logic [7:0]    out_data,
  output logic [IW-1:0] out_idx,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam int unsigned MAXC = (ERASE_CYCLES > EXPOSE_CYCLES) ?
      ((ERASE_CYCLES > CONVERT_CYCLES) ? ERASE_CYCLES : CONVERT_CYCLES) :
      ((EXPOSE_CYCLES > CONVERT_CYCLES) ? EXPOSE_CYCLES : CONVERT_CYCLES);
  localparam int unsigned CW = $clog2(MAXC + 1);

  localparam logic [CW-1:0] ERASE_LAST   = CW'(ERASE_CYCLES - 1);
  localparam logic [CW-1:0] EXPOSE_LAST  = CW'(EXPOSE_CYCLES - 1);
  localparam logic [CW-1:0] CONVERT_LAST = CW'(CONVERT_CYCLES - 1);
  localparam logic [AW-1:0] SIDE_LAST    = AW'(SIDE - 1);

  typedef enum logic [2:0] {
    IDLE, ERASE, EXPOSE, CONVERT, RD_DRIVE, RD_SAMPLE, RD_HOLD, DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] row_q, row_d, col_q, col_d;
  logic [7:0]    data_q, data_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          valid_q, valid_d;
  logic [IW-1:0] pix_idx;

  assign pix_idx = IW'(row_q) * IW'(SIDE) + IW'(col_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    data_d  = data_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = ERASE;
        cnt_d   = '0;
      end
      ERASE: if (cnt_q == ERASE_LAST) begin
        state_d = EXPOSE;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 1'b1;
      EXPOSE: if (cnt_q == EXPOSE_LAST) begin
        state_d = CONVERT;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 1'b1;
      CONVERT: if (cnt_q == CONVERT_LAST) begin
        state_d = RD_DRIVE;
        cnt_d   = '0;
        row_d   = '0;
        col_d   = '0;
      end else cnt_d = cnt_q + 1'b1;
      RD_DRIVE: state_d = RD_SAMPLE;
      RD_SAMPLE: begin
        data_d  = arr_data;
        idx_d   = pix_idx;
        valid_d = 1'b1;
        state_d = RD_HOLD;
      end
      RD_HOLD: if (valid_q && out_ready) begin
        valid_d = 1'b0;
        if (col_q == SIDE_LAST) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else col_d = col_q + 1'b1;
        state_d = (row_q == SIDE_LAST && col_q == SIDE_LAST) ? DONE : RD_DRIVE;
      end
      DONE: begin
        row_d   = '0;
        col_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Array controls decode from state alone, so phases cannot overlap.
  always_comb begin
    busy        = (state_q != IDLE);
    arr_reset_n = (state_q != IDLE);
    arr_erase   = (state_q == ERASE);
    arr_expose  = (state_q == EXPOSE);
    arr_bias    = (state_q == EXPOSE) || (state_q == CONVERT);
    arr_ramp    = (state_q == CONVERT);
    arr_read    = (state_q == RD_DRIVE) || (state_q == RD_SAMPLE);
    frame_done  = (state_q == DONE);
  end

  assign arr_row_addr = row_q;
  assign arr_col_addr = col_q;
  assign out_data     = data_q;
  assign out_idx      = idx_q;
  assign out_valid    = valid_q;

endmodule

// File: tb/tb_pixel_frame_ctrl.sv
// Directed bench for pixel_frame_ctrl with a 2x2 array model (data = 0x10 + 2*row + col).
module tb_pixel_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       busy, frame_done, arr_reset_n, arr_erase, arr_expose;
  logic       arr_bias, arr_ramp, arr_read;
  logic [0:0] arr_row_addr, arr_col_addr;
  logic [7:0] arr_data, out_data;
  logic [1:0] out_idx;
  logic       out_valid, out_ready;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  assign arr_data = 8'h10 + {6'd0, arr_row_addr, 1'b0} + {7'd0, arr_col_addr};

  pixel_frame_ctrl #(
    .num_pixels    (4),
    .ERASE_CYCLES  (4),
    .EXPOSE_CYCLES (10),
    .CONVERT_CYCLES(16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .busy        (busy),
    .frame_done  (frame_done),
    .arr_reset_n (arr_reset_n),
    .arr_erase   (arr_erase),
    .arr_expose  (arr_expose),
    .arr_bias    (arr_bias),
    .arr_ramp    (arr_ramp),
    .arr_read    (arr_read),
    .arr_row_addr(arr_row_addr),
    .arr_col_addr(arr_col_addr),
    .arr_data    (arr_data),
    .out_data    (out_data),
    .out_idx     (out_idx),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  // {busy, frame_done, arr_reset_n, erase, expose, bias, ramp, read, out_valid}
  logic [8:0] obs;
  assign obs = {busy, frame_done, arr_reset_n, arr_erase, arr_expose,
                arr_bias, arr_ramp, arr_read, out_valid};

  localparam logic [8:0] F_IDLE   = 9'b000000000;
  localparam logic [8:0] F_ERASE  = 9'b101100000;
  localparam logic [8:0] F_EXPOSE = 9'b101011000;
  localparam logic [8:0] F_CONV   = 9'b101001100;
  localparam logic [8:0] F_READ   = 9'b101000010;
  localparam logic [8:0] F_HOLD   = 9'b101000001;
  localparam logic [8:0] F_DONE   = 9'b111000000;

  typedef struct {
    logic        start;
    logic        ready;
    int unsigned n;
    logic [8:0]  flags;
    logic [1:0]  rc;
    logic [7:0]  data;
    logic [1:0]  idx;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic s, input logic r, input int unsigned n,
                     input logic [8:0] f, input logic [1:0] rc,
                     input logic [7:0] d, input logic [1:0] idx);
    vec_t v;
    v.start = s; v.ready = r; v.n = n; v.flags = f;
    v.rc = rc; v.data = d; v.idx = idx;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_vecs(input int unsigned lo, input int unsigned hi);
    for (int unsigned i = lo; i < hi; i++) begin
      start     = vecs[i].start;
      out_ready = vecs[i].ready;
      for (int unsigned c = 0; c < vecs[i].n; c++) begin
        tick();
        chk($sformatf("vec%0d.c%0d.flags", i, c), 32'(obs), 32'(vecs[i].flags));
        chk($sformatf("vec%0d.c%0d.addr", i, c), 32'({arr_row_addr, arr_col_addr}), 32'(vecs[i].rc));
        if (vecs[i].flags[0]) begin
          chk($sformatf("vec%0d.data", i), 32'(out_data), 32'(vecs[i].data));
          chk($sformatf("vec%0d.idx", i), 32'(out_idx), 32'(vecs[i].idx));
        end
      end
    end
    start = 1'b0;
  endtask

  int unsigned frame_lo, frame_hi;
  int unsigned n_erase, n_done, sent_hold;
  bit          found;

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;

    // Idle after reset, then one full frame with out_ready held high.
    add(0, 1, 20, F_IDLE, 2'b00, 8'h00, 2'd0);
    frame_lo = vecs.size();
    add(1, 1, 1,  F_ERASE,  2'b00, 8'h00, 2'd0);
    add(0, 1, 3,  F_ERASE,  2'b00, 8'h00, 2'd0);
    add(0, 1, 10, F_EXPOSE, 2'b00, 8'h00, 2'd0);
    add(0, 1, 16, F_CONV,   2'b00, 8'h00, 2'd0);
    add(0, 1, 1, F_READ, 2'b00, 8'h00, 2'd0);
    add(0, 1, 1, F_READ, 2'b00, 8'h00, 2'd0);
    add(0, 1, 1, F_HOLD, 2'b00, 8'h10, 2'd0);
    add(0, 1, 1, F_READ, 2'b01, 8'h00, 2'd0);
    add(0, 1, 1, F_READ, 2'b01, 8'h00, 2'd0);
    add(0, 1, 1, F_HOLD, 2'b01, 8'h11, 2'd1);
    add(0, 1, 1, F_READ, 2'b10, 8'h00, 2'd0);
    add(0, 1, 1, F_READ, 2'b10, 8'h00, 2'd0);
    add(0, 1, 1, F_HOLD, 2'b10, 8'h12, 2'd2);
    add(0, 1, 1, F_READ, 2'b11, 8'h00, 2'd0);
    add(0, 1, 1, F_READ, 2'b11, 8'h00, 2'd0);
    add(0, 1, 1, F_HOLD, 2'b11, 8'h13, 2'd3);
    add(0, 1, 1, F_DONE, 2'b00, 8'h00, 2'd0);
    add(0, 1, 2, F_IDLE, 2'b00, 8'h00, 2'd0);
    frame_hi = vecs.size();

    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_flags", 32'(obs), 32'(F_IDLE));
      chk("rst_addr", 32'({arr_row_addr, arr_col_addr}), 32'd0);
      chk("rst_out", 32'({out_data, out_idx}), 32'd0);
      tick();
    end
    reset_n = 1'b1;
    run_vecs(0, frame_hi);

    // Backpressure on pixel 1.
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      tick();
      if (out_valid && out_idx == 2'd1) found = 1'b1;
    end
    chk("bp_reach_pix1", 32'(found), 32'd1);
    out_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'h11);
      chk("bp_idx", 32'(out_idx), 32'd1);
      chk("bp_read", 32'(arr_read), 32'd0);
      chk("bp_addr", 32'({arr_row_addr, arr_col_addr}), 32'b01);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_resume_read", 32'(arr_read), 32'd1);
    chk("bp_resume_valid", 32'(out_valid), 32'd0);
    chk("bp_resume_addr", 32'({arr_row_addr, arr_col_addr}), 32'b10);
    n_done = 0;
    for (int k = 0; k < 50 && n_done == 0; k++) begin
      tick();
      if (frame_done) n_done++;
    end
    chk("bp_frame_done", n_done, 32'd1);
    tick();
    chk("bp_idle", 32'(obs), 32'(F_IDLE));

    // Start while busy is ignored; start during DONE is not queued.
    start = 1'b1; out_ready = 1'b1;
    n_erase = 0; n_done = 0; sent_hold = 0;
    for (int unsigned cyc = 1; cyc <= 60 && n_done == 0; cyc++) begin
      tick();
      start = 1'b0;
      if (arr_erase) n_erase++;
      if (frame_done) n_done++;
      if (cyc == 15) chk("sb_ramp_c15", 32'(arr_ramp), 32'd1);
      if (cyc == 31) chk("sb_read_c31", 32'(arr_read), 32'd1);
      if (cyc == 6) start = 1'b1;
      if (out_valid && sent_hold == 0) begin
        start = 1'b1;
        sent_hold = 1;
      end
    end
    chk("sb_erase_cycles", n_erase, 32'd4);
    chk("sb_one_done", n_done, 32'd1);
    chk("sb_hold_start_sent", sent_hold, 32'd1);
    start = 1'b1;
    tick();
    chk("sb_done_start_ignored", 32'(obs), 32'(F_IDLE));
    tick();
    chk("sb_new_frame", 32'(obs), 32'(F_ERASE));
    start = 1'b0;

    // Abort during CONVERT.
    repeat (19) tick();
    chk("ab_in_convert", 32'(obs), 32'(F_CONV));
    #2 reset_n = 1'b0;
    #1 chk("ab_conv_async", 32'(obs), 32'(F_IDLE));
    tick();
    chk("ab_conv_held", 32'(obs), 32'(F_IDLE));
    reset_n = 1'b1;
    tick();

    // Abort during RD_HOLD with out_valid high.
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      tick();
      if (out_valid) found = 1'b1;
    end
    chk("ab_reach_hold", 32'(found), 32'd1);
    #2 reset_n = 1'b0;
    #1 chk("ab_hold_async", 32'(obs), 32'(F_IDLE));
    chk("ab_hold_out", 32'({out_data, out_idx}), 32'd0);
    tick();
    chk("ab_hold_held", 32'(obs), 32'(F_IDLE));
    reset_n = 1'b1;
    tick();
    chk("ab_release_idle", 32'(obs), 32'(F_IDLE));

    run_vecs(frame_lo, frame_hi);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
